// File: rtl/fft_bitrev_buf_pkg.sv
// rtl/fft_bitrev_buf_pkg.sv - shared defaults for the FFT bit-reverse output buffer
// Purpose: default widths and frame size used by fft_bitrev_buf and fft_bitrev_ram.
// Ports: none (package).
package fft_bitrev_buf_pkg;

  localparam int DEF_W      = 16;  // bits per real/imag component
  localparam int DEF_N_LOG2 = 6;   // log2 of frame length
  localparam int DEF_CNT_W  = 16;  // frames_done counter width

endpackage

// File: rtl/fft_bitrev_ram.sv
// rtl/fft_bitrev_ram.sv - two-bank sample store, one write port, one asynchronous read port
// Purpose: holds two complete frames of complex samples, addressed as {bank, index}.
// Ports:
//   clk    in   rising-edge clock
//   we     in   write enable
//   waddr  in   write address {bank, index}
//   wdata  in   write data {real, imag}
//   raddr  in   read address {bank, index}
//   rdata  out  read data {real, imag}, combinational from raddr
module fft_bitrev_ram #(
  parameter int W      = 16,
  parameter int N_LOG2 = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [N_LOG2:0]   waddr,
  input  logic [2*W-1:0]    wdata,
  input  logic [N_LOG2:0]   raddr,
  output logic [2*W-1:0]    rdata
);

  localparam int DEPTH = 2 ** (N_LOG2 + 1);

  // No reset on the array so it maps onto distributed RAM; stale contents
  // are never read because the full flags gate every read.
  logic [2*W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_bitrev_buf.sv
// rtl/fft_bitrev_buf.sv - ping-pong reorder buffer turning bit-reversed FFT output into natural order
// Purpose: writes each sample at bitrev(write count) of the filling bank and reads the
//   draining bank sequentially into a valid/ready output register.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake
//   in_r, in_i            input sample, signed
//   out_valid/out_ready   output handshake
//   out_r, out_i          output sample, natural order
//   out_last              marks index N-1 of each frame
//   frames_done           count of fully emitted frames, wrapping
module fft_bitrev_buf
  import fft_bitrev_buf_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int N_LOG2 = DEF_N_LOG2,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_r,
  input  logic [W-1:0]     in_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_r,
  output logic [W-1:0]     out_i,
  output logic             out_last,
  output logic [CNT_W-1:0] frames_done
);

  localparam logic [N_LOG2-1:0] LAST_IDX = '1;

  logic [1:0]        full;
  logic [1:0]        full_nxt;
  logic              wr_bank;
  logic              rd_bank;
  logic [N_LOG2-1:0] wcnt;
  logic [N_LOG2-1:0] rcnt;
  logic [N_LOG2-1:0] wcnt_rev;
  logic              wr_fire;
  logic              load;
  logic              wr_end;
  logic              rd_end;
  logic [2*W-1:0]    rdata;

  always_comb begin
    wcnt_rev = '0;
    for (int b = 0; b < N_LOG2; b++) begin
      wcnt_rev[b] = wcnt[N_LOG2-1-b];
    end
  end

  // in_ready comes straight from the registered flag, so a bank freed this
  // cycle only admits new input next cycle.
  assign in_ready = ~full[wr_bank];
  assign wr_fire  = in_valid & in_ready;
  assign load     = full[rd_bank] & (~out_valid | out_ready);
  assign wr_end   = wr_fire & (wcnt == LAST_IDX);
  assign rd_end   = load & (rcnt == LAST_IDX);

  // Set and clear in one cycle always hit different banks: the writer only
  // fills a non-full bank and the reader only drains a full one.
  always_comb begin
    full_nxt = full;
    if (wr_end) full_nxt[wr_bank] = 1'b1;
    if (rd_end) full_nxt[rd_bank] = 1'b0;
  end

  fft_bitrev_ram #(
    .W      (W),
    .N_LOG2 (N_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .waddr ({wr_bank, wcnt_rev}),
    .wdata ({in_r, in_i}),
    .raddr ({rd_bank, rcnt}),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wcnt    <= '0;
      rcnt    <= '0;
    end else begin
      full <= full_nxt;
      if (wr_fire) begin
        wcnt <= wcnt + 1'b1;
        if (wr_end) wr_bank <= ~wr_bank;
      end
      if (load) begin
        rcnt <= rcnt + 1'b1;
        if (rd_end) rd_bank <= ~rd_bank;
      end
    end
  end

  // Output register: loads whenever it is empty or being emptied, otherwise
  // holds its contents while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_r       <= '0;
      out_i       <= '0;
      frames_done <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_last  <= (rcnt == LAST_IDX);
        out_r     <= rdata[2*W-1:W];
        out_i     <= rdata[W-1:0];
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready && out_last) begin
        frames_done <= frames_done + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_buf.sv
// tb/tb_fft_bitrev_buf.sv - scoreboard bench for fft_bitrev_buf with N=8, W=16
module tb_fft_bitrev_buf;

  localparam int NL = 3;
  localparam int N  = 1 << NL;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_r;
  logic [15:0] in_i;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_r;
  logic [15:0] out_i;
  logic        out_last;
  logic [15:0] frames_done;

  fft_bitrev_buf #(.W(16), .N_LOG2(NL), .CNT_W(16)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_r        (in_r),
    .in_i        (in_i),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_r       (out_r),
    .out_i       (out_i),
    .out_last    (out_last),
    .frames_done (frames_done)
  );

  typedef struct {
    logic [15:0] r;
    logic [15:0] i;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] part_r[N];
  logic [15:0] part_i[N];
  int          pcnt;
  int          exp_frames;
  int          nvec;
  int          nmis;
  int          rmode;
  bit          prev_stall;
  logic [15:0] prev_r;
  logic [15:0] prev_i;
  logic        prev_last;
  bit          b2_on;
  bit          b2_started;
  int          b2_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int brev(input int k);
    int r;
    r = 0;
    for (int b = 0; b < NL; b++) begin
      if (k[b]) r = r | (1 << (NL - 1 - b));
    end
    return r;
  endfunction

  // out_ready pattern: 0 always ready, 1 never ready, 2 toggling, 3 random
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = 1'b0;
        2: out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: samples handshakes mid-cycle; the transfers take effect on the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      pcnt       = 0;
      exp_frames = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_r", 32'(out_r), 32'(prev_r));
        chk("hold_i", 32'(out_i), 32'(prev_i));
        chk("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (in_valid && in_ready) begin
        part_r[pcnt] = in_r;
        part_i[pcnt] = in_i;
        pcnt++;
        if (pcnt == N) begin
          // write j lands at address bitrev(j), so natural index k holds write bitrev(k)
          for (int k = 0; k < N; k++) begin
            sb.push_back('{part_r[brev(k)], part_i[brev(k)], (k == N - 1)});
          end
          pcnt = 0;
        end
      end
      if (b2_on) begin
        if (out_valid) b2_started = 1'b1;
        if (b2_started && b2_cnt < 4 * N) chk("no_bubble", 32'(out_valid), 32'd1);
      end
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("out_r", 32'(out_r), 32'(e.r));
          chk("out_i", 32'(out_i), 32'(e.i));
          chk("out_last", 32'(out_last), 32'(e.last));
          if (e.last) exp_frames++;
        end
        if (b2_on) b2_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_r     = out_r;
      prev_i     = out_i;
      prev_last  = out_last;
    end
  end

  task automatic push(input logic [15:0] r, input logic [15:0] i, input int gap, output int waits);
    bit f;
    waits    = 0;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_r     = r;
    in_i     = i;
    forever begin
      @(negedge clk);
      f = in_ready;
      @(posedge clk);
      #1;
      if (f) break;
      waits++;
      if (waits > 2000) begin
        chk("push_timeout", 32'(waits), 32'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic push_frame(input int base, input int maxgap, input bit nowait);
    int w;
    for (int j = 0; j < N; j++) begin
      push(16'(base + j), 16'(-(base + j)), (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)), w);
      if (nowait) chk("in_ready_steady", 32'(w), 32'd0);
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid && pcnt == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_done", 32'(done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    nvec = 0; nmis = 0; rmode = 0;
    b2_on = 1'b0; b2_started = 1'b0; b2_cnt = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_r = '0; in_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_r", 32'(out_r), 32'd0);
    chk("rst_out_i", 32'(out_i), 32'd0);
    chk("rst_frames_done", 32'(frames_done), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // 1: single frame, latency and reorder
    push_frame(0, 0, 1'b0);
    @(negedge clk);
    chk("lat_t1_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("lat_t2_valid", 32'(out_valid), 32'd1);
    chk("lat_t2_r", 32'(out_r), 32'd0);
    wait_drain();
    chk("t1_frames", 32'(frames_done), 32'd1);

    // 2: four frames back to back, no bubbles on output
    b2_on = 1'b1; b2_started = 1'b0; b2_cnt = 0;
    push_frame(16, 0, 1'b0);
    for (int f = 1; f < 4; f++) push_frame(16 + 8 * f, 0, 1'b1);
    wait_drain();
    b2_on = 1'b0;
    chk("t2_frames", 32'(frames_done), 32'd5);

    // 3: consumer stalled, both banks fill, 17th sample held
    rmode = 1;
    @(posedge clk);
    #1;
    push_frame(0, 0, 1'b0);
    push_frame(8, 0, 1'b0);
    in_valid = 1'b1; in_r = 16'd16; in_i = 16'(-16);
    repeat (4) begin
      @(negedge clk);
      chk("t3_in_ready", 32'(in_ready), 32'd0);
      chk("t3_out_valid", 32'(out_valid), 32'd1);
      chk("t3_out_r", 32'(out_r), 32'd0);
      @(posedge clk);
      #1;
    end
    rmode = 0;
    push(16'd16, 16'(-16), 0, w);
    for (int j = 1; j < N; j++) push(16'(16 + j), 16'(-(16 + j)), 0, w);
    wait_drain();
    chk("t3_frames", 32'(frames_done), 32'(exp_frames));
    chk("t3_frames_abs", 32'(frames_done), 32'd8);

    // 4: toggling out_ready
    rmode = 2;
    push_frame(200, 0, 1'b0);
    push_frame(300, 0, 1'b0);
    wait_drain();
    chk("t4_frames", 32'(frames_done), 32'd10);

    // 5: asynchronous reset mid-frame while draining
    rmode = 0;
    push_frame(40, 0, 1'b0);
    for (int j = 0; j < 5; j++) push(16'(48 + j), 16'(-(48 + j)), 0, w);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_r", 32'(out_r), 32'd0);
    chk("t5_rst_i", 32'(out_i), 32'd0);
    chk("t5_rst_last", 32'(out_last), 32'd0);
    chk("t5_rst_frames", 32'(frames_done), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    push_frame(0, 0, 1'b0);
    wait_drain();
    chk("t5_frames", 32'(frames_done), 32'd1);

    // 6: random in_valid gaps and random out_ready, 20 frames
    rmode = 3;
    for (int f = 0; f < 20; f++) push_frame(1000 + 8 * f, 2, 1'b0);
    rmode = 0;
    wait_drain();
    chk("t6_frames", 32'(frames_done), 32'(exp_frames));
    chk("t6_frames_abs", 32'(frames_done), 32'd21);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
